// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg: constants shared by the bus timer and anything that talks to
// it. Holds the register word offsets, MODE encodings, CTRL bit positions,
// the FSM state type and a byte-lane merge helper.
package bus_timer_pkg;

   // Register byte offsets inside the 16-byte window (0xC is unmapped).
   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_PRESET = 4'h4;
   localparam logic [3:0] OFF_COUNT  = 4'h8;

   // CTRL.MODE encodings; 2'b10 and 2'b11 behave as one-shot.
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // CTRL bit positions.
   localparam int unsigned CTRL_EN       = 0;
   localparam int unsigned CTRL_MODE_LSB = 1;
   localparam int unsigned CTRL_IM       = 3;
   localparam int unsigned CTRL_W        = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   // Replace only the bytes whose lane enable is set.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped countdown timer on the CPU data bus.
// Registers: CTRL (EN, MODE, IM) at +0x0, PRESET at +0x4, COUNT (read-only)
// at +0x8. A four-state FSM reloads COUNT from PRESET, counts down to zero
// and raises an interrupt flag; irq = flag & CTRL.IM.
// Ports:
//   clk     in   single clock, rising edge
//   reset   in   synchronous, active-high
//   addr    in   [31:0] byte address
//   byteen  in   [3:0]  byte-lane write enables (0 = read / no write)
//   wdata   in   [31:0] lane-aligned write data
//   rdata   out  [31:0] combinational read data of the addressed register
//   irq     out  level interrupt request
module bus_timer
   import bus_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   state_e              state_q, state_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
   logic [31:0]         preset_q, preset_d;
   logic [31:0]         count_q, count_d;
   logic                flag_q, flag_d;

   logic hit, wr_ctrl, wr_preset;
   logic en, reload_mode;

   // Byte offset within a word does not affect register selection.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^addr[1:0];

   assign en          = ctrl_q[CTRL_EN];
   assign reload_mode = (ctrl_q[CTRL_MODE_LSB +: 2] == MODE_RELOAD);

   always_comb begin
      hit       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
      wr_ctrl   = hit && (byteen != 4'b0000) && (addr[3:2] == OFF_CTRL[3:2]);
      wr_preset = hit && (byteen != 4'b0000) && (addr[3:2] == OFF_PRESET[3:2]);
   end

   always_comb begin
      rdata = 32'h0;
      if (hit) begin
         if (addr[3:2] == OFF_CTRL[3:2])        rdata = {28'h0, ctrl_q};
         else if (addr[3:2] == OFF_PRESET[3:2]) rdata = preset_q;
         else if (addr[3:2] == OFF_COUNT[3:2])  rdata = count_q;
      end
   end

   assign irq = flag_q && ctrl_q[CTRL_IM];

   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      flag_d   = flag_q;

      unique case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (count_q != 32'h0) begin
               count_d = count_q - 32'd1;
            end else begin
               flag_d  = 1'b1;
               state_d = ST_INT;
            end
         end
         ST_INT: begin
            // Auto-reload drops the flag and leaves EN set so IDLE reloads;
            // one-shot keeps the flag and disables itself.
            if (reload_mode) flag_d = 1'b0;
            else             ctrl_d[CTRL_EN] = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A CPU write on the same edge overrides the FSM's effect on CTRL and
      // the flag; the FSM's state transition still happens.
      if (wr_ctrl) begin
         if (byteen[0]) ctrl_d = wdata[CTRL_W-1:0];
         flag_d = 1'b0;
      end
      if (wr_preset) preset_d = merge_lanes(preset_q, wdata, byteen);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ctrl_q   <= '0;
         preset_q <= 32'h0;
         count_q  <= 32'h0;
         flag_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         flag_q   <= flag_d;
      end
   end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed bench for bus_timer with a cycle model of the
// timer's register-level behaviour and literal spot checks.
module tb_bus_timer;

   localparam logic [31:0] BASE = 32'h0000_7F00;
   localparam logic [31:0] A_CTRL   = BASE + 32'h0;
   localparam logic [31:0] A_PRESET = BASE + 32'h4;
   localparam logic [31:0] A_COUNT  = BASE + 32'h8;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_vec = 0;
   int n_bad = 0;

   bus_timer #(.BASE_ADDR(BASE)) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .byteen (byteen),
      .wdata  (wdata),
      .rdata  (rdata),
      .irq    (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   // phase: 0 waiting for EN, 1 about to load, 2 counting, 3 just expired
   logic [3:0]  m_ctrl;
   logic [31:0] m_preset, m_count;
   logic        m_flag;
   int          m_phase;
   bit          m_valid = 0;

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a[31:4] != BASE[31:4]) return 32'h0;
      case (a[3:2])
         2'd0:    return {28'h0, m_ctrl};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk) begin
      logic [3:0]  c;
      logic [31:0] p, n;
      logic        f;
      int          ph;
      if (reset) begin
         m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0; m_phase = 0;
         m_valid = 1;
      end else if (m_valid) begin
         c = m_ctrl; p = m_preset; n = m_count; f = m_flag; ph = m_phase;
         if (m_phase == 0) begin
            if (m_ctrl[0]) ph = 1;
         end else if (m_phase == 1) begin
            n = m_preset; ph = 2;
         end else if (m_phase == 2) begin
            if (!m_ctrl[0])         ph = 0;
            else if (m_count > 0)   n = m_count - 1;
            else begin f = 1; ph = 3; end
         end else begin
            if (m_ctrl[2:1] == 2'b01) f = 0;
            else                      c[0] = 0;
            ph = 0;
         end
         if (addr[31:4] == BASE[31:4] && byteen != 0) begin
            if (addr[3:2] == 2'd0) begin
               if (byteen[0]) c = wdata[3:0];
               f = 0;
            end else if (addr[3:2] == 2'd1) begin
               for (int i = 0; i < 4; i++)
                  if (byteen[i]) p[8*i +: 8] = wdata[8*i +: 8];
            end
         end
         m_ctrl = c; m_preset = p; m_count = n; m_flag = f; m_phase = ph;
      end
   end

   // Continuous compare against the model on the falling edge.
   always @(negedge clk) begin
      if (m_valid) begin
         n_vec++;
         if (rdata !== m_read(addr) || irq !== (m_flag && m_ctrl[3])) begin
            n_bad++;
            $display("FAIL model t=%0t addr=%h: rdata=%h irq=%b, model rdata=%h irq=%b",
                     $time, addr, rdata, irq, m_read(addr), m_flag && m_ctrl[3]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      addr = a; byteen = be; wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(32'h0, 4'h0, 32'h0);
   endtask

   task automatic chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
      addr = a; byteen = 4'h0;
      #1;
      n_vec++;
      if (rdata !== exp) begin
         n_bad++;
         $display("FAIL %s: rdata=%h expected %h", nm, rdata, exp);
      end
   endtask

   task automatic chk_irq(input logic exp, input string nm);
      n_vec++;
      if (irq !== exp) begin
         n_bad++;
         $display("FAIL %s: irq=%b expected %b", nm, irq, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      reset = 1'b1; addr = 0; byteen = 0; wdata = 0;
      do_reset();

      // Reset state
      chk(A_CTRL,   32'h0, "rst_ctrl");
      chk(A_PRESET, 32'h0, "rst_preset");
      chk(A_COUNT,  32'h0, "rst_count");
      chk(BASE + 32'hC, 32'h0, "rst_unmapped");
      chk_irq(1'b0, "rst_irq");

      // One-shot with IM, PRESET=5
      step(A_PRESET, 4'hF, 32'd5);
      step(A_CTRL, 4'hF, 32'h9);             // edge 0
      idle(2);                               // edges 1,2
      chk(A_COUNT, 32'd5, "os_count_e2");
      idle(5);                               // edges 3..7
      chk(A_COUNT, 32'd0, "os_count_e7");
      chk_irq(1'b0, "os_irq_e7");
      idle(1);                               // edge 8
      chk_irq(1'b1, "os_irq_e8");
      idle(1);                               // edge 9: EN auto-cleared
      chk(A_CTRL, 32'h8, "os_ctrl_after");
      chk_irq(1'b1, "os_irq_held");
      idle(3);
      chk_irq(1'b1, "os_irq_still");
      step(A_CTRL, 4'hF, 32'h0);
      chk_irq(1'b0, "os_irq_cleared");
      chk(BASE + 32'h7, 32'd5, "addr_lsb_ignored");
      step(BASE + 32'h14, 4'hF, 32'hDEAD);   // outside window
      chk(A_PRESET, 32'd5, "miss_write");

      // Auto-reload with IM, PRESET=3
      do_reset();
      step(A_PRESET, 4'hF, 32'd3);
      step(A_CTRL, 4'hF, 32'hB);             // edge 0
      for (int e = 1; e <= 21; e++) begin
         idle(1);
         chk_irq((e == 6 || e == 13 || e == 20), $sformatf("ar_irq_e%0d", e));
      end
      step(A_CTRL, 4'hF, 32'h0);

      // Byte-lane merge, CTRL upper bits, COUNT read-only
      do_reset();
      step(A_PRESET, 4'hF, 32'h1234_5678);
      step(A_PRESET, 4'b0001, 32'hFFFF_FFAA);
      chk(A_PRESET, 32'h1234_56AA, "be_merge");
      step(A_COUNT, 4'hF, 32'hDEAD_BEEF);
      chk(A_COUNT, 32'h0, "count_ro");
      step(A_CTRL, 4'hF, 32'hFFFF_FFF8);
      chk(A_CTRL, 32'h8, "ctrl_upper_dropped");
      step(A_CTRL, 4'hF, 32'h0);

      // EN cleared during count
      do_reset();
      step(A_PRESET, 4'hF, 32'd10);
      step(A_CTRL, 4'hF, 32'h1);             // edge 0, IM=0
      idle(5);                               // edges 1..5
      chk(A_COUNT, 32'd7, "en_count7");
      step(A_CTRL, 4'hF, 32'h0);             // edge 6
      chk(A_COUNT, 32'd6, "en_count6");
      idle(3);
      chk(A_COUNT, 32'd6, "en_frozen");
      chk_irq(1'b0, "en_no_irq");

      // IM=0 completion: no irq, one-shot self-disables
      step(A_PRESET, 4'hF, 32'd2);
      step(A_CTRL, 4'hF, 32'h1);             // edge 0
      idle(6);                               // edges 1..6
      chk(A_CTRL, 32'h0, "im0_ctrl");
      chk(A_COUNT, 32'h0, "im0_count");
      chk_irq(1'b0, "im0_irq");

      // Reset mid-count
      do_reset();
      step(A_PRESET, 4'hF, 32'd5);
      step(A_CTRL, 4'hF, 32'h9);             // edge 0
      idle(5);
      chk(A_COUNT, 32'd2, "mr_count2");
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      chk(A_CTRL,   32'h0, "mr_ctrl");
      chk(A_PRESET, 32'h0, "mr_preset");
      chk(A_COUNT,  32'h0, "mr_count");
      chk_irq(1'b0, "mr_irq");
      idle(12);
      chk_irq(1'b0, "mr_irq_later");

      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
